filter_rx_pkt_buffer: RTL and testbench

- Store-and-forward packet buffer placed directly downstream of the RX filter pipeline, in front of the QDMA C2H AXI-Stream input in box_250mhz.
- Absorbs QDMA backpressure without stalling the filter, because s_axis_tready is held high after reset.
- Releases only complete packets downstream.
- When space runs out, drops the whole offending packet and never emits a truncated one.

---
 rtl/filter_rx_pkt_buffer.sv | 141 ++++++++++++++
 tb/tb_filter_rx_pkt_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_rx_pkt_buffer.sv
// Store-and-forward RX packet buffer: releases only committed packets, drops whole packets on overflow.
// Optional high-water-mark port pair enabled by FILTER_RX_PKT_BUFFER_HWM_EN.
module filter_rx_pkt_buffer #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          s_axis_tvalid,
  input  logic [511:0]  s_axis_tdata,
  input  logic [63:0]   s_axis_tkeep,
  input  logic          s_axis_tlast,
  input  logic [47:0]   s_axis_tuser,
  output logic          s_axis_tready,
  output logic          m_axis_tvalid,
  output logic [511:0]  m_axis_tdata,
  output logic [63:0]   m_axis_tkeep,
  output logic          m_axis_tlast,
  output logic [47:0]   m_axis_tuser,
  input  logic          m_axis_tready,
  output logic [AW:0]   occupancy,
  output logic [31:0]   fwd_pkt_count,
  output logic [31:0]   ovf_drop_count
`ifdef FILTER_RX_PKT_BUFFER_HWM_EN
  ,
  input  logic          hwm_clr,
  output logic [AW:0]   hwm
`endif
);

  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;
  localparam int USER_W = 48;
  localparam int ENT_W  = USER_W + 1 + KEEP_W + DATA_W;
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  typedef enum logic {ST_WRITE, ST_DROP} state_t;

  state_t            state_q, state_d;
  logic [AW:0]       wr_q, wr_d, cm_q, cm_d, fe_q, fe_d, rd_q, rd_d, occ_q;
  logic [31:0]       fwd_q, fwd_d, ovf_q, ovf_d;
  logic              vld_p0_q, vld_p0_d;
  logic [ENT_W-1:0]  out_p0_q;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic              acc, full, wr_en, fe_en, pop;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign s_axis_tready = aresetn;
  assign acc   = s_axis_tvalid && aresetn;
  assign full  = ((wr_q - rd_q) == DEPTH_V);
  // fe_q fetches into the output register; rd_q only moves on the downstream handshake,
  // so the beat held in the output register still occupies its memory slot.
  assign pop   = vld_p0_q && m_axis_tready;
  assign fe_en = (cm_q != fe_q) && (!vld_p0_q || m_axis_tready);

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    cm_d     = cm_q;
    fwd_d    = fwd_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    fe_d     = fe_en ? fe_q + ONE : fe_q;
    rd_d     = pop ? rd_q + ONE : rd_q;
    vld_p0_d = fe_en ? 1'b1 : (m_axis_tready ? 1'b0 : vld_p0_q);
    if (acc) begin
      case (state_q)
        ST_WRITE: begin
          if (!full) begin
            wr_en = 1'b1;
            wr_d  = wr_q + ONE;
            if (s_axis_tlast) begin
              cm_d  = wr_q + ONE;
              fwd_d = sat_inc(fwd_q);
            end
          end else begin
            wr_d  = cm_q;
            ovf_d = sat_inc(ovf_q);
            if (!s_axis_tlast) state_d = ST_DROP;
          end
        end
        default: begin
          if (s_axis_tlast) state_d = ST_WRITE;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_WRITE;
      wr_q     <= '0;
      cm_q     <= '0;
      fe_q     <= '0;
      rd_q     <= '0;
      occ_q    <= '0;
      fwd_q    <= '0;
      ovf_q    <= '0;
      vld_p0_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      cm_q     <= cm_d;
      fe_q     <= fe_d;
      rd_q     <= rd_d;
      occ_q    <= wr_d - rd_d;
      fwd_q    <= fwd_d;
      ovf_q    <= ovf_d;
      vld_p0_q <= vld_p0_d;
    end
  end

  // Stage p0: synchronous-read memory feeding the output register
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_q[AW-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    if (fe_en) out_p0_q <= mem[fe_q[AW-1:0]];
  end

  assign m_axis_tvalid = vld_p0_q;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_p0_q;
  assign occupancy      = occ_q;
  assign fwd_pkt_count  = fwd_q;
  assign ovf_drop_count = ovf_q;

`ifdef FILTER_RX_PKT_BUFFER_HWM_EN
  logic [AW:0] hwm_q;

  always_ff @(posedge aclk) begin
    if (!aresetn)           hwm_q <= '0;
    else if (hwm_clr)       hwm_q <= occ_q;
    else if (occ_q > hwm_q) hwm_q <= occ_q;
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_filter_rx_pkt_buffer.sv
// Directed bench for filter_rx_pkt_buffer (DEPTH=8), immediate-assertion checking.
module tb_filter_rx_pkt_buffer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [511:0]  s_tdata = '0;
  logic [63:0]   s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic [47:0]   s_tuser = '0;
  logic          s_tready;
  logic          m_tvalid;
  logic [511:0]  m_tdata;
  logic [63:0]   m_tkeep;
  logic          m_tlast;
  logic [47:0]   m_tuser;
  logic          m_tready = 1'b0;
  logic [AW:0]   occ;
  logic [31:0]   fwd_cnt, ovf_cnt;

  int checks = 0;
  int failures = 0;

  filter_rx_pkt_buffer #(.DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .occupancy(occ), .fwd_pkt_count(fwd_cnt), .ovf_drop_count(ovf_cnt)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  function automatic logic [511:0] mkd(input int k);
    return {16{32'hC0DE_0000 | 32'(k)}};
  endfunction

  function automatic logic [47:0] mku(input int k);
    return {16'hBEEF, 32'(k)};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic beat(input int k, input logic last);
    s_tvalid = 1'b1;
    s_tdata  = mkd(k);
    s_tuser  = mku(k);
    s_tkeep  = '1;
    s_tlast  = last;
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic pkt(input int k0, input int n);
    for (int i = 0; i < n; i++) beat(k0 + i, (i == n - 1));
  endtask

  task automatic do_reset(input string tag);
    aresetn = 1'b0;
    tick();
    chk({tag, "_rst_mvalid"}, m_tvalid, 1'b0);
    chk({tag, "_rst_sready"}, s_tready, 1'b0);
    chk({tag, "_rst_fwd"}, fwd_cnt, 0);
    chk({tag, "_rst_ovf"}, ovf_cnt, 0);
    chk({tag, "_rst_occ"}, occ, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk({tag, "_sready_on"}, s_tready, 1'b1);
  endtask

  task automatic drain(input string tag, input int k0, input int n);
    int w;
    w = 0;
    m_tready = 1'b1;
    while (!m_tvalid && w < 20) begin
      tick();
      w++;
    end
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), m_tvalid, 1'b1);
      chk($sformatf("%s_data%0d", tag, i), m_tdata, mkd(k0 + i));
      chk($sformatf("%s_user%0d", tag, i), m_tuser, mku(k0 + i));
      chk($sformatf("%s_last%0d", tag, i), m_tlast, (i == n - 1));
      tick();
    end
    chk({tag, "_idle"}, m_tvalid, 1'b0);
  endtask

  initial begin
    @(negedge aclk);

    // single-beat packet, latency of two cycles
    do_reset("t1");
    m_tready = 1'b1;
    beat(1, 1'b1);
    chk("t1_lat_cycle1", m_tvalid, 1'b0);
    tick();
    chk("t1_valid", m_tvalid, 1'b1);
    chk("t1_data", m_tdata, mkd(1));
    chk("t1_user", m_tuser, mku(1));
    chk("t1_keep", m_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_last", m_tlast, 1'b1);
    chk("t1_fwd", fwd_cnt, 1);
    tick();
    chk("t1_after", m_tvalid, 1'b0);
    chk("t1_occ", occ, 0);

    // 3-beat packet held under backpressure
    m_tready = 1'b0;
    pkt(10, 3);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("t2_stall_v%0d", c), m_tvalid, 1'b1);
      chk($sformatf("t2_stall_d%0d", c), m_tdata, mkd(10));
    end
    chk("t2_occ", occ, 3);
    drain("t2", 10, 3);
    chk("t2_fwd", fwd_cnt, 2);

    // second packet does not fit behind the first
    do_reset("t3");
    m_tready = 1'b0;
    pkt(20, 5);
    pkt(30, 5);
    tick();
    chk("t3_ovf", ovf_cnt, 1);
    chk("t3_fwd", fwd_cnt, 1);
    chk("t3_occ", occ, 5);
    drain("t3", 20, 5);
    chk("t3_occ_end", occ, 0);

    // exactly DEPTH beats fits, next packet is dropped
    do_reset("t4");
    m_tready = 1'b0;
    pkt(40, 8);
    tick();
    chk("t4_occ_full", occ, 8);
    chk("t4_fwd", fwd_cnt, 1);
    pkt(50, 1);
    tick();
    chk("t4_ovf", ovf_cnt, 1);
    chk("t4_occ", occ, 8);
    drain("t4", 40, 8);

    // oversized packet never reaches the output
    do_reset("t5");
    m_tready = 1'b1;
    pkt(60, 12);
    tick();
    chk("t5_valid", m_tvalid, 1'b0);
    chk("t5_ovf", ovf_cnt, 1);
    chk("t5_fwd", fwd_cnt, 0);
    chk("t5_occ", occ, 0);
    pkt(70, 2);
    drain("t5", 70, 2);
    chk("t5_fwd_after", fwd_cnt, 1);

    // reset in the middle of a packet
    do_reset("t6");
    m_tready = 1'b1;
    pkt(100, 1);
    beat(80, 1'b0);
    beat(81, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = mkd(82);
    s_tuser  = mku(82);
    aresetn  = 1'b0;
    tick();
    chk("t6_mid_mvalid", m_tvalid, 1'b0);
    chk("t6_mid_sready", s_tready, 1'b0);
    chk("t6_mid_fwd", fwd_cnt, 0);
    chk("t6_mid_ovf", ovf_cnt, 0);
    chk("t6_mid_occ", occ, 0);
    s_tvalid = 1'b0;
    aresetn  = 1'b1;
    tick();
    beat(90, 1'b1);
    drain("t6", 90, 1);
    chk("t6_fwd", fwd_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
